ru_wb_arbiter: RTL

Shares the single write port of Register_Unit between two writeback requesters: req0 = ALU/WB path, req1 = load/MEM path. Each requester has a DEPTH-entry FIFO, and a round-robin arbiter drains the FIFOs into a registered write stage that drives RUWr/rd/RUDataWr. The block also exports a combinational pending-write mask that the hazard unit uses to stall reads of registers not yet committed.

---
 rtl/ru_wb_pkg.sv | 22 ++
 rtl/ru_wb_fifo.sv | 70 +++++++
 rtl/ru_wb_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/ru_wb_pkg.sv
// Shared types for the Register_Unit writeback arbiter: queued entry layout
// and the wrap-safe age compare on sequence tags.
package ru_wb_pkg;

   // Must satisfy 2**(SEQW-1) > 2*DEPTH+1; use 5 when DEPTH=4.
   localparam int SEQW = 4;
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [4:0]      rd;
      logic [31:0]     data;
      logic [SEQW-1:0] seq;
   } wb_entry_t;

   // True when tag a was issued before tag b, valid across counter wrap.
   function automatic logic seq_older(input logic [SEQW-1:0] a, input logic [SEQW-1:0] b);
      logic [SEQW-1:0] d;
      d = a - b;
      return d[SEQW-1];
   endfunction

endpackage

// File: rtl/ru_wb_fifo.sv
// Per-requester writeback queue with a registered not-full ready and a one-hot
// mask of destination registers still held in the queue.
module ru_wb_fifo
   import ru_wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  wb_entry_t   din,
   input  logic        pop,
   output wb_entry_t   head,
   output logic        empty,
   output logic        ready,
   output logic [31:0] pend
);
   localparam int AW = $clog2(DEPTH);

   wb_entry_t [DEPTH-1:0] mem;
   logic [DEPTH-1:0]      slot_vld;
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           count, count_nxt;

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + (AW+1)'(1);
      else if (pop && !push)
         count_nxt = count - (AW+1)'(1);
   end

   // ready reflects occupancy after the edge, so a pop never raises it combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         slot_vld <= '0;
         ready    <= 1'b0;
      end else begin
         count <= count_nxt;
         ready <= (count_nxt != (AW+1)'(DEPTH));
         if (push) begin
            wr_ptr           <= wr_ptr + AW'(1);
            slot_vld[wr_ptr] <= 1'b1;
         end
         if (pop) begin
            rd_ptr           <= rd_ptr + AW'(1);
            slot_vld[rd_ptr] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= din;
   end

   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++)
         if (slot_vld[i])
            pend[mem[i].rd] = 1'b1;
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/ru_wb_arbiter.sv
// Two-requester writeback arbiter for the single Register_Unit write port:
// age-tagged FIFOs, round-robin/age arbitration, registered write stage, busy mask.
module ru_wb_arbiter
   import ru_wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [4:0]  req0_rd,
   input  logic [31:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [4:0]  req1_rd,
   input  logic [31:0] req1_data,
   output logic        req1_ready,
   output logic        RUWr,
   output logic [4:0]  rd,
   output logic [31:0] RUDataWr,
   output logic [31:0] busy
);
   wb_entry_t       in0, in1, head0, head1, win;
   logic            push0, push1, empty0, empty1;
   logic            gnt0, gnt1, both, commit, rr_ptr;
   logic [31:0]     pend0, pend1;
   logic [SEQW-1:0] seq_q;

   assign push0 = req0_valid & req0_ready;
   assign push1 = req1_valid & req1_ready;

   // On a simultaneous accept the load is the older instruction and takes the lower tag.
   assign in1 = '{rd: req1_rd, data: req1_data, seq: seq_q};
   assign in0 = '{rd: req0_rd, data: req0_data, seq: (push1 ? seq_q + SEQW'(1) : seq_q)};

   ru_wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
      .clk(clk), .rst_n(rst_n), .push(push0), .din(in0), .pop(gnt0),
      .head(head0), .empty(empty0), .ready(req0_ready), .pend(pend0)
   );

   ru_wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
      .clk(clk), .rst_n(rst_n), .push(push1), .din(in1), .pop(gnt1),
      .head(head1), .empty(empty1), .ready(req1_ready), .pend(pend1)
   );

   assign both = !empty0 && !empty1;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (both) begin
         if (head0.rd == head1.rd) begin
            if (seq_older(head0.seq, head1.seq)) gnt0 = 1'b1;
            else                                 gnt1 = 1'b1;
         end else if (rr_ptr) begin
            gnt1 = 1'b1;
         end else begin
            gnt0 = 1'b1;
         end
      end else if (!empty0) begin
         gnt0 = 1'b1;
      end else if (!empty1) begin
         gnt1 = 1'b1;
      end
   end

   assign win    = gnt1 ? head1 : head0;
   assign commit = (gnt0 | gnt1) && (win.rd != REG_ZERO);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RUWr     <= 1'b0;
         rd       <= '0;
         RUDataWr <= '0;
         rr_ptr   <= 1'b0;
         seq_q    <= '0;
      end else begin
         RUWr  <= commit;
         seq_q <= seq_q + SEQW'(push0) + SEQW'(push1);
         if (commit) begin
            rd       <= win.rd;
            RUDataWr <= win.data;
         end
         if (both)
            rr_ptr <= ~rr_ptr;
      end
   end

   always_comb begin
      busy = pend0 | pend1;
      if (RUWr)
         busy[rd] = 1'b1;
      busy[REG_ZERO] = 1'b0;
   end

endmodule
